sigma_delta_decimator: RTL



---
 rtl/sigma_delta_decimator.sv | 119 +++++++++++
 1 files changed

// File: rtl/sigma_delta_decimator.sv
// Two-channel 3rd-order CIC decimator: turns 1-bit PDM left/right streams into
// saturated signed PCM samples, with a one-clock valid strobe after CIC priming.
module sigma_delta_decimator #(
  parameter int DR = 6,
  parameter int OW = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_en,
  input  logic                 left_in,
  input  logic                 right_in,
  output logic signed [OW-1:0] ldata,
  output logic signed [OW-1:0] rdata,
  output logic                 sample_valid
);

  localparam int W  = 3 * DR + 2;
  localparam int S  = 3 * DR - (OW - 1);
  localparam int SR = (S >= 0) ? S : 0;
  localparam int SL = (S < 0) ? -S : 0;
  localparam int YW = W + OW;
  localparam logic signed [YW-1:0] MAXV = YW'((64'sd1 <<< (OW - 1)) - 64'sd1);
  localparam logic signed [YW-1:0] MINV = -MAXV - YW'(1);

  // Index 0 is the left channel, index 1 the right channel.
  logic signed [W-1:0]  i1_q [2];
  logic signed [W-1:0]  i2_q [2];
  logic signed [W-1:0]  i3_q [2];
  logic signed [W-1:0]  d1_q [2];
  logic signed [W-1:0]  d2_q [2];
  logic signed [W-1:0]  d3_q [2];
  logic signed [W-1:0]  i1_d [2];
  logic signed [W-1:0]  i2_d [2];
  logic signed [W-1:0]  i3_d [2];
  logic signed [W-1:0]  c1   [2];
  logic signed [W-1:0]  c2   [2];
  logic signed [W-1:0]  c3   [2];
  logic signed [W-1:0]  x    [2];
  logic signed [YW-1:0] yext [2];
  logic signed [YW-1:0] ysc  [2];
  logic signed [OW-1:0] ysat [2];

  logic [1:0]           bits;
  logic [DR-1:0]        cnt_q;
  logic [1:0]           prime_q;
  logic signed [OW-1:0] ldata_q;
  logic signed [OW-1:0] rdata_q;
  logic                 valid_q;
  logic                 tick;

  assign bits = {right_in, left_in};
  assign tick = bit_en && (&cnt_q);

  // Integrator/comb arithmetic wraps modulo 2^W; the combs cancel the wrap.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      x[ch]    = bits[ch] ? W'(1) : {W{1'b1}};
      i1_d[ch] = i1_q[ch] + x[ch];
      i2_d[ch] = i2_q[ch] + i1_q[ch];
      i3_d[ch] = i3_q[ch] + i2_q[ch];
      c1[ch]   = i3_q[ch] - d1_q[ch];
      c2[ch]   = c1[ch] - d2_q[ch];
      c3[ch]   = c2[ch] - d3_q[ch];
      yext[ch] = {{(YW - W){c3[ch][W-1]}}, c3[ch]};
      ysc[ch]  = (yext[ch] >>> SR) <<< SL;
      if (ysc[ch] > MAXV)
        ysat[ch] = MAXV[OW-1:0];
      else if (ysc[ch] < MINV)
        ysat[ch] = MINV[OW-1:0];
      else
        ysat[ch] = ysc[ch][OW-1:0];
    end
  end

  // Integrators advance on every enabled bit; combs, outputs and priming only on ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < 2; ch++) begin
        i1_q[ch] <= '0;
        i2_q[ch] <= '0;
        i3_q[ch] <= '0;
        d1_q[ch] <= '0;
        d2_q[ch] <= '0;
        d3_q[ch] <= '0;
      end
      cnt_q   <= '0;
      prime_q <= '0;
      ldata_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
    end else begin
      if (bit_en) begin
        for (int ch = 0; ch < 2; ch++) begin
          i1_q[ch] <= i1_d[ch];
          i2_q[ch] <= i2_d[ch];
          i3_q[ch] <= i3_d[ch];
        end
        cnt_q <= cnt_q + DR'(1);
      end
      if (tick) begin
        for (int ch = 0; ch < 2; ch++) begin
          d1_q[ch] <= i3_q[ch];
          d2_q[ch] <= c1[ch];
          d3_q[ch] <= c2[ch];
        end
        ldata_q <= ysat[0];
        rdata_q <= ysat[1];
        if (prime_q != 2'd3)
          prime_q <= prime_q + 2'd1;
      end
      valid_q <= tick && (prime_q == 2'd3);
    end
  end

  assign ldata        = ldata_q;
  assign rdata        = rdata_q;
  assign sample_valid = valid_q;

endmodule
